// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   PC register and instruction-fetch sequencer. Holds CurrentPC, fetches the word at
//   CurrentPC over a valid/ready request / valid-only response memory interface, and
//   presents the registered instruction downstream. On downstream accept, CurrentPC
//   loads NextPC; a misaligned NextPC parks the unit in a sticky fault state.
//
// Ports
//   CLK           in   clock, rising edge
//   resetl        in   asynchronous active-low reset
//   NextPC        in   next PC from next-PC logic, sampled only on accept
//   CurrentPC     out  architectural PC
//   IMemReqValid  out  fetch request valid (registered)
//   IMemReqAddr   out  fetch address, equals CurrentPC
//   IMemReqReady  in   memory accepts the request
//   IMemRespValid in   response data valid (single-cycle pulse)
//   IMemRespData  in   fetched instruction word
//   Instruction   out  registered instruction for decode
//   InstrValid    out  Instruction holds valid data
//   InstrAccept   in   downstream consumes Instruction this cycle
//   PCFault       out  sticky misaligned-PC flag
//   InstrCount    out  accepted-instruction counter, wraps at 2^32

module pc_fetch_unit #(
  parameter int unsigned           PC_WIDTH    = 64,
  parameter int unsigned           INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_PC    = '0
) (
  input  logic                   CLK,
  input  logic                   resetl,
  input  logic [PC_WIDTH-1:0]    NextPC,
  output logic [PC_WIDTH-1:0]    CurrentPC,
  output logic                   IMemReqValid,
  output logic [PC_WIDTH-1:0]    IMemReqAddr,
  input  logic                   IMemReqReady,
  input  logic                   IMemRespValid,
  input  logic [INSTR_WIDTH-1:0] IMemRespData,
  output logic [INSTR_WIDTH-1:0] Instruction,
  output logic                   InstrValid,
  input  logic                   InstrAccept,
  output logic                   PCFault,
  output logic [31:0]            InstrCount
);

  typedef enum logic [1:0] {StReq, StWait, StHold, StFault} state_e;

  state_e                  state_q, state_d;
  logic [PC_WIDTH-1:0]     pc_q;
  logic                    req_valid_q;
  logic [INSTR_WIDTH-1:0]  instr_q;
  logic                    instr_valid_q;
  logic                    fault_q;
  logic [31:0]             count_q;

  logic accept;
  logic resp_take;
  logic misaligned;

  assign accept     = (state_q == StHold) && InstrAccept;
  assign resp_take  = (state_q == StWait) && IMemRespValid;
  assign misaligned = (NextPC[1:0] != 2'b00);

  // State register
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state_q <= StReq;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. The handshake only counts once the registered valid is up, so
  // IMemReqReady in the first cycle after reset is ignored.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StReq:   if (req_valid_q && IMemReqReady) state_d = StWait;
      StWait:  if (IMemRespValid)               state_d = StHold;
      StHold:  if (InstrAccept)                 state_d = misaligned ? StFault : StReq;
      StFault: state_d = StFault;
      default: state_d = StReq;
    endcase
  end

  // Datapath registers
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      pc_q          <= RESET_PC;
      req_valid_q   <= 1'b0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      fault_q       <= 1'b0;
      count_q       <= '0;
    end else begin
      // Valid is registered: high in every cycle the FSM sits in REQ, which also
      // raises it the cycle right after an accept.
      req_valid_q <= (state_d == StReq);
      if (resp_take) begin
        instr_q       <= IMemRespData;
        instr_valid_q <= 1'b1;
      end
      if (accept) begin
        instr_valid_q <= 1'b0;
        count_q       <= count_q + 32'd1;
        pc_q          <= NextPC;
        if (misaligned) begin
          fault_q <= 1'b1;
        end
      end
    end
  end

  // Outputs
  always_comb begin
    CurrentPC    = pc_q;
    IMemReqValid = req_valid_q;
    IMemReqAddr  = pc_q;
    Instruction  = instr_q;
    InstrValid   = instr_valid_q;
    PCFault      = fault_q;
    InstrCount   = count_q;
  end

endmodule
